mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage LoongArch32 pipeline, between EXE and WB.
//  - Collects data-SRAM responses (sram-like data_ok) for loads/stores issued by EXE.
//  - Extracts and extends load data.
//  - Forwards the result to ID for bypass and passes the packed bus to WB.
//  - Discards responses that belong to instructions flushed by WB exception or ERTN.
// PARAMETERS
//  DISCARD_W   2   width of the pending-response discard counter (max 2^W-1 outstanding)
// PORTS
//  clk              in   1    clock
//  reset            in   1    synchronous, active-high
//  ws_allowin       in   1    WB can accept
//  ms_allowin       out  1    MEM can accept
//  es_to_ms_valid   in   1    EXE has an instruction for MEM
//  es_to_ms_bus     in   `ES_TO_MS_BUS_WD   {csr_we,csr_wnum,csr_wmask,csr_wdata,ertn,exc_flgs,mem_req,ld_op[2:0],ld_uns,gr_we,dest,alu_result,pc}
//  ms_to_ws_valid   out  1    MEM hands instruction to WB
//  ms_to_ws_bus     out  `MS_TO_WS_BUS_WD   {csr_we,csr_wnum,csr_wmask,csr_wdata,ertn,exc_flgs,gr_we,dest,final_result,pc}
//  data_sram_data_ok in  1    data response valid (one cycle per accepted request)
//  data_sram_rdata  in   32   response data
//  wb_exc           in   1    WB taking exception: flush
//  ertn_flush       in   1    WB executing ERTN: flush
//  ms_fwd_bus       out  39   {fwd_we,fwd_dest[4:0],fwd_data[31:0],fwd_pending} to ID
//  ms_csr_blk_bus   out  16   {csr_we&valid, ertn&valid, csr_wnum[13:0]} to ID
//  ms_ex            out  1    MEM holds exc/ertn: EXE must not issue new requests
// BEHAVIOUR
//  - Reset: ms_valid=0, discard_cnt=0, buf_valid=0. All valid-qualified outputs 0.
//  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
//  - ms_to_ws_valid = ms_valid & ms_ready_go & ~flush, where flush = wb_exc|ertn_flush.
//  - Pipe register: on flush, ms_valid<=0.
//    Else if ms_allowin, ms_valid<=es_to_ms_valid and the bus is latched when es_to_ms_valid.
//  - Data-wait: a valid instr with mem_req=1 needs its data_ok.
//    ms_ready_go = ~mem_req | resp_here, where resp_here = (data_ok & discard_cnt==0) | buf_valid.
//    If exc_flgs!=0 then mem_req=0 by contract, so ready_go=1.
//  - Response buffer: data_ok (not discarded) while ms_valid & ~ws_allowin
//    -> buf_valid<=1, buf_data<=rdata. Cleared when the instr leaves MEM or on flush.
//  - Discard: flush while ms_valid & mem_req & ~resp_here -> discard_cnt+1.
//    A data_ok with discard_cnt!=0 -> discard_cnt-1; data is dropped and is not a response for the current instr.
//    Increment and decrement in the same cycle -> net 0.
//  - Load extract (addr=alu_result[1:0]) for ld_op b/h/w:
//    - Select byte or halfword by addr.
//    - ld_uns zero-extends; otherwise sign-extend to 32 bits.
//    - w uses the full word.
//    - final_result = mem_req&load ? extracted : alu_result (stores keep the address).
//  - Forward: fwd_we = ms_valid & gr_we. fwd_pending = fwd_we & load & ~resp_here (ID must stall).
//  - ms_ex = ms_valid & (|exc_flgs | ertn). Combinational. No added latency; MEM is 1 cycle when not waiting.
//  - Reset mid-wait: counter and buffer clear; responses outstanding across reset are the bus's responsibility.
// CONFIGURATION
//  MEM_RESP_BUF_EN
//  - Defined: response buffer as above.
//  - Undefined: no buffer (buf_valid tied 0); data_ok is consumed directly.
//    WB must hold ws_allowin=1 whenever a non-discarded data_ok arrives for a valid instr.
//    A simulation assertion flags a violation.
// TESTING
//  1. ld.b at addr 0x..03, rdata=0x80FF_1234, data_ok 2 cycles late
//     -> ms_ready_go 0 for 2 cycles, then final_result=0xFFFF_FF80, fwd_pending falls with data_ok.
//  2. ld.hu at addr 0x..02, rdata=0x8001_FFFF -> final_result=0x0000_8001. ld.w -> 0x8001_FFFF.
//  3. Load waiting, wb_exc pulses
//     -> ms_valid=0 next cycle, discard_cnt=1.
//     -> next data_ok dropped, cnt=0, the following instr's data_ok accepted.
//  4. Flush and stale data_ok same cycle with cnt=1 -> cnt stays 1, no ms_to_ws_valid.
//  5. (MEM_RESP_BUF_EN) data_ok while ws_allowin=0 -> buf_valid=1; ws_allowin=1 next -> ms_to_ws_valid with buffered data, buf cleared.
//  6. exc_flgs=ALE, mem_req=0 -> ms_ready_go=1 at once, ms_ex=1, bus passed unchanged.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage LoongArch32 pipeline (between EXE and WB).
//   Waits for the data-SRAM response (sram-like data_ok) of loads/stores issued
//   by EXE. It extracts and extends load data, forwards the result to ID for
//   bypass, and passes the packed bus to WB. Responses that belong to
//   instructions flushed by a WB exception or ERTN are counted and dropped.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ws_allowin          WB can accept
//   ms_allowin          MEM can accept
//   es_to_ms_valid/bus  instruction from EXE
//                       {csr_we,csr_wnum[13:0],csr_wmask,csr_wdata,ertn,exc_flgs[5:0],
//                        mem_req,ld_op[2:0],ld_uns,gr_we,dest[4:0],alu_result,pc}
//                       ld_op is one-hot: [0]=byte, [1]=halfword, [2]=word
//   ms_to_ws_valid/bus  instruction to WB
//                       {csr_we,csr_wnum,csr_wmask,csr_wdata,ertn,exc_flgs,gr_we,dest,final_result,pc}
//   data_sram_data_ok   one pulse per accepted data request
//   data_sram_rdata     response data
//   wb_exc, ertn_flush  flush requests from WB
//   ms_fwd_bus          {fwd_we,fwd_dest[4:0],fwd_data[31:0],fwd_pending} to ID
//   ms_csr_blk_bus      {csr_we&valid,ertn&valid,csr_wnum[13:0]} to ID
//   ms_ex               MEM holds an exception/ERTN; EXE must not issue requests
//
// Build option MEM_RESP_BUF_EN: when defined, a one-entry response buffer
// holds data that arrives while WB stalls. When undefined, WB must keep
// ws_allowin high whenever a live response arrives. A simulation assertion
// checks this.

`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 161
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 156
`endif

module mem_stage #(
    parameter int unsigned DISCARD_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ws_allowin,
    output logic                        ms_allowin,
    input  logic                        es_to_ms_valid,
    input  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                        ms_to_ws_valid,
    output logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata,
    input  logic                        wb_exc,
    input  logic                        ertn_flush,
    output logic [38:0]                 ms_fwd_bus,
    output logic [15:0]                 ms_csr_blk_bus,
    output logic                        ms_ex
);

    logic                        ms_valid;
    logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        ertn;
    logic [5:0]  exc_flgs;
    logic        mem_req;
    logic [2:0]  ld_op;
    logic        ld_uns;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {csr_we, csr_wnum, csr_wmask, csr_wdata, ertn, exc_flgs, mem_req,
            ld_op, ld_uns, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;

    logic                 flush;
    logic                 ms_ready_go;
    logic                 resp_here;
    logic                 live_ok;
    logic [DISCARD_W-1:0] discard_cnt;
    logic                 discard_inc;
    logic                 discard_dec;
    logic                 buf_valid;
    logic [31:0]          rdata_sel;
    logic                 is_load;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          load_val;
    logic [31:0]          final_result;
    logic                 fwd_we;

    assign flush = wb_exc | ertn_flush;

    // A data_ok is only ours when no flushed request is still outstanding.
    assign live_ok   = data_sram_data_ok & (discard_cnt == '0);
    assign resp_here = live_ok | buf_valid;

    assign ms_ready_go    = ~mem_req | resp_here;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && ms_allowin && es_to_ms_valid) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // Each flushed request that still has not received its response will
    // produce one stale data_ok later. Count these so they can be dropped.
    assign discard_inc = flush & ms_valid & mem_req & ~resp_here;
    assign discard_dec = data_sram_data_ok & (discard_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (discard_inc && !discard_dec) begin
            discard_cnt <= discard_cnt + DISCARD_W'(1);
        end else if (!discard_inc && discard_dec) begin
            discard_cnt <= discard_cnt - DISCARD_W'(1);
        end
    end

`ifdef MEM_RESP_BUF_EN
    logic [31:0] buf_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (flush || (ms_to_ws_valid && ws_allowin)) begin
            buf_valid <= 1'b0;
        end else if (live_ok && ms_valid && !ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    assign rdata_sel = buf_valid ? buf_data : data_sram_rdata;
`else
    assign buf_valid = 1'b0;
    assign rdata_sel = data_sram_rdata;

    // With no buffer, a live response seen while WB stalls would be lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(ms_valid && mem_req && live_ok && !ws_allowin && !flush));
        end
    end
`endif

    assign is_load = mem_req & (|ld_op);

    always_comb begin
        ld_byte = 8'h00;
        case (alu_result[1:0])
            2'd0: ld_byte = rdata_sel[7:0];
            2'd1: ld_byte = rdata_sel[15:8];
            2'd2: ld_byte = rdata_sel[23:16];
            2'd3: ld_byte = rdata_sel[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half  = alu_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        load_val = rdata_sel;
        if (ld_op[0]) begin
            load_val = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
        end else if (ld_op[1]) begin
            load_val = {{16{~ld_uns & ld_half[15]}}, ld_half};
        end
        final_result = is_load ? load_val : alu_result;
    end

    assign ms_to_ws_bus = {csr_we, csr_wnum, csr_wmask, csr_wdata, ertn, exc_flgs,
                           gr_we, dest, final_result, pc};

    assign fwd_we         = ms_valid & gr_we;
    assign ms_fwd_bus     = {fwd_we, dest, final_result, fwd_we & is_load & ~resp_here};
    assign ms_csr_blk_bus = {csr_we & ms_valid, ertn & ms_valid, csr_wnum};
    assign ms_ex          = ms_valid & ((|exc_flgs) | ertn);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage load extraction, data wait,
// flush/discard handling, WB stall, exception pass-through and reset.
module tb_mem_stage;

    localparam int ES_W = 161;
    localparam int WS_W = 156;
    localparam logic [2:0]  NOLD  = 3'b000;
    localparam logic [2:0]  LD_B  = 3'b001;
    localparam logic [2:0]  LD_H  = 3'b010;
    localparam logic [2:0]  LD_W  = 3'b100;
    localparam logic [31:0] WMASK = 32'h0000_00FF;
    localparam logic [31:0] WDATA = 32'h1234_5678;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ws_allowin = 1'b1;
    logic            ms_allowin;
    logic            es_to_ms_valid = 1'b0;
    logic [ES_W-1:0] es_to_ms_bus = '0;
    logic            ms_to_ws_valid;
    logic [WS_W-1:0] ms_to_ws_bus;
    logic            data_sram_data_ok = 1'b0;
    logic [31:0]     data_sram_rdata = '0;
    logic            wb_exc = 1'b0;
    logic            ertn_flush = 1'b0;
    logic [38:0]     ms_fwd_bus;
    logic [15:0]     ms_csr_blk_bus;
    logic            ms_ex;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.DISCARD_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_exc            (wb_exc),
        .ertn_flush        (ertn_flush),
        .ms_fwd_bus        (ms_fwd_bus),
        .ms_csr_blk_bus    (ms_csr_blk_bus),
        .ms_ex             (ms_ex)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [ES_W-1:0] es(input logic csr_we, input logic [13:0] wnum,
                                           input logic [5:0] exc, input logic ertn,
                                           input logic mem_req, input logic [2:0] ld_op,
                                           input logic ld_uns, input logic gr_we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {csr_we, wnum, WMASK, WDATA, ertn, exc, mem_req, ld_op, ld_uns, gr_we, dest, alu, pc};
    endfunction

    function automatic logic [WS_W-1:0] ws(input logic csr_we, input logic [13:0] wnum,
                                           input logic [5:0] exc, input logic ertn,
                                           input logic gr_we, input logic [4:0] dest,
                                           input logic [31:0] res, input logic [31:0] pc);
        return {csr_we, wnum, WMASK, WDATA, ertn, exc, gr_we, dest, res, pc};
    endfunction

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one memory op, answer it in the following cycle, check the result.
    task automatic run_load(input string tag, input logic [2:0] op, input logic uns,
                            input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp);
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, op, uns, 1'b1, 5'd9, addr, 32'h1c00_0100);
        tick;
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        check({tag, "_valid"}, 160'(ms_to_ws_valid), 160'(1'b1));
        check({tag, "_result"}, 160'(ms_to_ws_bus[63:32]), 160'(exp));
        tick;
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        // Reset
        tick;
        tick;
        check("rst_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        check("rst_allowin", 160'(ms_allowin), 160'(1'b1));
        check("rst_fwd_we", 160'(ms_fwd_bus[38]), 160'(1'b0));
        check("rst_ex", 160'(ms_ex), 160'(1'b0));
        check("rst_csr_blk", 160'(ms_csr_blk_bus[15:14]), 160'(2'b00));
        check("rst_cnt", 160'(dut.discard_cnt), 160'(2'd0));
        reset = 1'b0;

        // ld.b at ...03, response two cycles late
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_B, 1'b0, 1'b1, 5'd5, 32'h0000_1003, 32'h1c00_0010);
        tick;
        es_to_ms_valid = 1'b0;
        #1;
        check("t1_w1_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        check("t1_w1_pend", 160'(ms_fwd_bus[0]), 160'(1'b1));
        check("t1_w1_allowin", 160'(ms_allowin), 160'(1'b0));
        tick;
        check("t1_w2_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        tick;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        check("t1_valid", 160'(ms_to_ws_valid), 160'(1'b1));
        check("t1_bus", 160'(ms_to_ws_bus),
              160'(ws(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, 5'd5, 32'hFFFF_FF80, 32'h1c00_0010)));
        check("t1_fwd", 160'(ms_fwd_bus), 160'({1'b1, 5'd5, 32'hFFFF_FF80, 1'b0}));
        tick;
        data_sram_data_ok = 1'b0;
        #1;
        check("t1_gone", 160'(ms_to_ws_valid), 160'(1'b0));

        // Load extraction variants and a store
        run_load("ld_hu", LD_H, 1'b1, 32'h0000_2002, 32'h8001_FFFF, 32'h0000_8001);
        run_load("ld_w",  LD_W, 1'b0, 32'h0000_2000, 32'h8001_FFFF, 32'h8001_FFFF);
        run_load("ld_h",  LD_H, 1'b0, 32'h0000_2000, 32'h8001_FFFF, 32'hFFFF_FFFF);
        run_load("ld_bu", LD_B, 1'b1, 32'h0000_2002, 32'h8001_FFFF, 32'h0000_0001);
        run_load("ld_b1", LD_B, 1'b0, 32'h0000_2001, 32'h80FF_7F34, 32'h0000_007F);
        run_load("st",    NOLD, 1'b0, 32'h0000_2008, 32'hFFFF_FFFF, 32'h0000_2008);

        // Non-memory instruction held by a WB stall
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b0, NOLD, 1'b0, 1'b1, 5'd3, 32'hAAAA_5555, 32'h1c00_0020);
        tick;
        ws_allowin   = 1'b0;
        es_to_ms_bus = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b0, NOLD, 1'b0, 1'b1, 5'd4, 32'h5555_AAAA, 32'h1c00_0024);
        #1;
        check("stall_valid", 160'(ms_to_ws_valid), 160'(1'b1));
        check("stall_allowin", 160'(ms_allowin), 160'(1'b0));
        check("stall_fwd", 160'(ms_fwd_bus), 160'({1'b1, 5'd3, 32'hAAAA_5555, 1'b0}));
        tick;
        ws_allowin = 1'b1;
        #1;
        check("stall_hold", 160'(ms_to_ws_bus[63:32]), 160'(32'hAAAA_5555));
        tick;
        es_to_ms_valid = 1'b0;
        #1;
        check("stall_next", 160'(ms_to_ws_bus[63:32]), 160'(32'h5555_AAAA));
        tick;
        check("stall_gone", 160'(ms_to_ws_valid), 160'(1'b0));

        // Flush while waiting: the next data_ok is stale and dropped
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd6, 32'h0000_3000, 32'h1c00_0030);
        tick;
        es_to_ms_valid = 1'b0;
        wb_exc         = 1'b1;
        #1;
        check("t3_flush_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        tick;
        wb_exc         = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd7, 32'h0000_3004, 32'h1c00_0034);
        #1;
        check("t3_cnt1", 160'(dut.discard_cnt), 160'(2'd1));
        check("t3_allowin", 160'(ms_allowin), 160'(1'b1));
        tick;
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_0000;
        #1;
        check("t3_stale_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        check("t3_stale_pend", 160'(ms_fwd_bus[0]), 160'(1'b1));
        tick;
        data_sram_rdata = 32'h0BAD_F00D;
        #1;
        check("t3_cnt0", 160'(dut.discard_cnt), 160'(2'd0));
        check("t3_valid", 160'(ms_to_ws_valid), 160'(1'b1));
        check("t3_result", 160'(ms_to_ws_bus[63:32]), 160'(32'h0BAD_F00D));
        tick;
        data_sram_data_ok = 1'b0;

        // Flush and stale data_ok in the same cycle: count is unchanged
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd8, 32'h0000_4000, 32'h1c00_0040);
        tick;
        es_to_ms_valid = 1'b0;
        wb_exc         = 1'b1;
        tick;
        wb_exc         = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd9, 32'h0000_4004, 32'h1c00_0044);
        #1;
        check("t4_cnt1", 160'(dut.discard_cnt), 160'(2'd1));
        tick;
        es_to_ms_valid    = 1'b0;
        ertn_flush        = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        check("t4_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        tick;
        ertn_flush        = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        check("t4_cnt_held", 160'(dut.discard_cnt), 160'(2'd1));
        check("t4_fwd_we", 160'(ms_fwd_bus[38]), 160'(1'b0));
        tick;
        data_sram_data_ok = 1'b1;
        tick;
        data_sram_data_ok = 1'b0;
        #1;
        check("t4_cnt0", 160'(dut.discard_cnt), 160'(2'd0));

`ifdef MEM_RESP_BUF_EN
        // Response arrives while WB stalls; the buffer holds it
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd11, 32'h0000_5000, 32'h1c00_0050);
        tick;
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h00C0_FFEE;
        #1;
        check("t5_valid0", 160'(ms_to_ws_valid), 160'(1'b1));
        check("t5_allowin", 160'(ms_allowin), 160'(1'b0));
        tick;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        check("t5_buf", 160'(dut.buf_valid), 160'(1'b1));
        check("t5_result", 160'(ms_to_ws_bus[63:32]), 160'(32'h00C0_FFEE));
        check("t5_pend", 160'(ms_fwd_bus[0]), 160'(1'b0));
        tick;
        ws_allowin = 1'b1;
        #1;
        check("t5_valid1", 160'(ms_to_ws_valid), 160'(1'b1));
        check("t5_result1", 160'(ms_to_ws_bus[63:32]), 160'(32'h00C0_FFEE));
        tick;
        check("t5_buf_clr", 160'(dut.buf_valid), 160'(1'b0));
        check("t5_gone", 160'(ms_to_ws_valid), 160'(1'b0));
`endif

        // Exception-flagged instruction passes through unchanged
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b1, 14'h0006, 6'b000100, 1'b0, 1'b0, LD_W, 1'b0, 1'b0, 5'd10, 32'h0000_3001, 32'h1c00_0060);
        tick;
        es_to_ms_valid = 1'b0;
        #1;
        check("t6_valid", 160'(ms_to_ws_valid), 160'(1'b1));
        check("t6_ex", 160'(ms_ex), 160'(1'b1));
        check("t6_bus", 160'(ms_to_ws_bus),
              160'(ws(1'b1, 14'h0006, 6'b000100, 1'b0, 1'b0, 5'd10, 32'h0000_3001, 32'h1c00_0060)));
        check("t6_csr_blk", 160'(ms_csr_blk_bus), 160'({1'b1, 1'b0, 14'h0006}));
        check("t6_fwd_we", 160'(ms_fwd_bus[38]), 160'(1'b0));
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b1, 1'b0, NOLD, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1c00_0064);
        tick;
        es_to_ms_valid = 1'b0;
        #1;
        check("ertn_ex", 160'(ms_ex), 160'(1'b1));
        check("ertn_csr_blk", 160'(ms_csr_blk_bus), 160'({1'b0, 1'b1, 14'h0}));
        tick;
        check("ex_clear", 160'(ms_ex), 160'(1'b0));

        // Reset while a discard is pending clears the counter
        tick;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd12, 32'h0000_6000, 32'h1c00_0070);
        tick;
        es_to_ms_valid = 1'b0;
        wb_exc         = 1'b1;
        tick;
        wb_exc         = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es(1'b0, 14'h0, 6'h0, 1'b0, 1'b1, LD_W, 1'b0, 1'b1, 5'd13, 32'h0000_6004, 32'h1c00_0074);
        tick;
        es_to_ms_valid = 1'b0;
        reset          = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("rst2_cnt", 160'(dut.discard_cnt), 160'(2'd0));
        check("rst2_valid", 160'(ms_to_ws_valid), 160'(1'b0));
        check("rst2_allowin", 160'(ms_allowin), 160'(1'b1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
